dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single-port 8 KB data memory (1024 x 64-bit, combinational read, synchronous write). It shares the memory between the core's load/store path (port 0) and the debug/program-loader path (port 1) using round-robin arbitration. It checks addresses, drives the memory strobes for exactly one cycle per access, and returns a registered response to the winning requester.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter_rr_arb2.sv | 20 ++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared definitions.
// State encoding, port indices and address check helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int PORT_CORE     = 0;
    localparam int PORT_DBG      = 1;
    localparam int DEF_MEM_BYTES = 8192;

    // Full 64-bit range compare plus doubleword alignment; no wrap.
    function automatic logic addr_ok(
        input logic [63:0] a,
        input int unsigned bytes
    );
        return (a < 64'(bytes)) && (a[2:0] == 3'b000);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: two request/response ports
// and the single-port data memory side.
interface dmem_arbiter_if #(
    parameter int DATA_W = 64
);
    logic              rq0_valid;
    logic              rq0_ready;
    logic              rq0_write;
    logic [63:0]       rq0_addr;
    logic [DATA_W-1:0] rq0_wdata;

    logic              rq1_valid;
    logic              rq1_ready;
    logic              rq1_write;
    logic [63:0]       rq1_addr;
    logic [DATA_W-1:0] rq1_wdata;

    logic              rs0_valid;
    logic [DATA_W-1:0] rs0_rdata;
    logic              rs0_err;

    logic              rs1_valid;
    logic [DATA_W-1:0] rs1_rdata;
    logic              rs1_err;

    logic [63:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  rq0_valid, rq0_write, rq0_addr, rq0_wdata,
        input  rq1_valid, rq1_write, rq1_addr, rq1_wdata,
        output rq0_ready, rq1_ready,
        output rs0_valid, rs0_rdata, rs0_err,
        output rs1_valid, rs1_rdata, rs1_err,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );

    modport master (
        output rq0_valid, rq0_write, rq0_addr, rq0_wdata,
        output rq1_valid, rq1_write, rq1_addr, rq1_wdata,
        input  rq0_ready, rq1_ready,
        input  rs0_valid, rs0_rdata, rs0_err,
        input  rs1_valid, rs1_rdata, rs1_err,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker, purely combinational.
// On contention the port that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    // One-hot grant from requests and previous winner
    always_comb begin
        o_gnt = 2'b00;
        unique case (1'b1)
            (i_req == 2'b01): o_gnt = 2'b01;
            (i_req == 2'b10): o_gnt = 2'b10;
            (i_req == 2'b11): o_gnt = i_last ? 2'b01 : 2'b10;
            default:          o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of the single-port data memory between
// the core load/store path and the debug/loader path.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES,
    parameter int DATA_W    = 64
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    state_t            r_state;
    logic              r_last;
    logic              r_win;
    logic              r_write;
    logic [63:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [1:0]        r_rs_valid;

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_idle;
    logic              w_ok;
    logic              w_acc;

    assign w_req  = {bus.rq1_valid, bus.rq0_valid};
    assign w_idle = (r_state == ST_IDLE);
    assign w_ok   = addr_ok(r_addr, MEM_BYTES);
    assign w_acc  = reset && (r_state == ST_ACCESS) && w_ok;

    rr_arb2 u_arb (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    // Ready is combinational and only offered while idle and out of reset
    assign bus.rq0_ready = reset && w_idle && w_gnt[PORT_CORE];
    assign bus.rq1_ready = reset && w_idle && w_gnt[PORT_DBG];

    // Strobes gated by reset so an abandoned store never commits
    assign bus.mem_read  = w_acc && !r_write;
    assign bus.mem_write = w_acc && r_write;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    // Only the winning port sees the captured response
    assign bus.rs0_valid = r_rs_valid[PORT_CORE];
    assign bus.rs0_rdata = r_rs_valid[PORT_CORE] ? r_rdata : '0;
    assign bus.rs0_err   = r_rs_valid[PORT_CORE] && r_err;
    assign bus.rs1_valid = r_rs_valid[PORT_DBG];
    assign bus.rs1_rdata = r_rs_valid[PORT_DBG] ? r_rdata : '0;
    assign bus.rs1_err   = r_rs_valid[PORT_DBG] && r_err;

    // Sequencer: accept, access for one cycle, respond for one cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_win      <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_rs_valid <= 2'b00;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_rs_valid <= 2'b00;
                    if (|w_req) begin
                        r_last  <= w_gnt[PORT_DBG];
                        r_win   <= w_gnt[PORT_DBG];
                        r_write <= w_gnt[PORT_DBG] ? bus.rq1_write
                                                   : bus.rq0_write;
                        r_addr  <= w_gnt[PORT_DBG] ? bus.rq1_addr
                                                   : bus.rq0_addr;
                        r_wdata <= w_gnt[PORT_DBG] ? bus.rq1_wdata
                                                   : bus.rq0_wdata;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_rdata    <= (w_ok && !r_write) ? bus.mem_rdata
                                                     : '0;
                    r_err      <= !w_ok;
                    r_rs_valid <= r_win ? 2'b10 : 2'b01;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    r_rs_valid <= 2'b00;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_rs_valid <= 2'b00;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic
// compared every cycle against a timing/memory reference model.
module tb_dmem_arbiter;

    import dmem_arb_pkg::*;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    typedef struct {
        int          port;
        int          due;
        logic [63:0] rdata;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .MEM_BYTES (8192),
        .DATA_W    (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [63:0] ram  [1024];
    logic [63:0] gold [1024];

    assign bus.mem_rdata = ram[bus.mem_addr[12:3]];

    // Memory device: synchronous write
    always @(posedge clk)
        if (bus.mem_write) ram[bus.mem_addr[12:3]] <= bus.mem_wdata;

    req_t q0[$];
    req_t q1[$];
    rsp_t pend[$];

    int   cyc = 0;
    int   free_cyc = 0;
    int   strb_cyc = -1;
    int   last = 1;
    int   gap0 = 0;
    int   gap1 = 0;
    bit   gaps_on = 0;
    bit   rst_prev_low = 1;
    logic exp_rd = 0;
    logic exp_wr = 0;
    int   wr_idx = 0;
    logic [63:0] wr_dat = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      tag, got, exp, cyc);
    endtask

    function automatic bit in_range(input logic [63:0] a);
        return (a < 64'd8192) && (a % 64'd8 == 64'd0);
    endfunction

    task automatic drive();
        if (gap0 > 0) begin
            gap0--;
            bus.rq0_valid = 1'b0;
        end else if (q0.size() > 0) begin
            bus.rq0_valid = 1'b1;
            bus.rq0_write = q0[0].wr;
            bus.rq0_addr  = q0[0].addr;
            bus.rq0_wdata = q0[0].wdata;
        end else begin
            bus.rq0_valid = 1'b0;
        end
        if (gap1 > 0) begin
            gap1--;
            bus.rq1_valid = 1'b0;
        end else if (q1.size() > 0) begin
            bus.rq1_valid = 1'b1;
            bus.rq1_write = q1[0].wr;
            bus.rq1_addr  = q1[0].addr;
            bus.rq1_wdata = q1[0].wdata;
        end else begin
            bus.rq1_valid = 1'b0;
        end
    endtask

    // Reference model evaluated at each negedge
    task automatic sample();
        logic [1:0]  v;
        logic [1:0]  eg;
        logic [1:0]  ev;
        logic [63:0] erd;
        logic        eer;
        req_t        r;
        rsp_t        s;
        bit          ok;
        cyc++;
        if (!reset && rst_prev_low) begin
            chk("rst_mem_addr", bus.mem_addr, 64'd0);
            chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
        end
        chk("mem_read", {63'd0, bus.mem_read},
            {63'd0, reset && cyc == strb_cyc && exp_rd});
        chk("mem_write", {63'd0, bus.mem_write},
            {63'd0, reset && cyc == strb_cyc && exp_wr});
        if (reset && cyc == strb_cyc && exp_wr) gold[wr_idx] = wr_dat;
        ev = 2'b00;
        erd = 64'd0;
        eer = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            s = pend.pop_front();
            ev[s.port] = 1'b1;
            erd = s.rdata;
            eer = s.err;
        end
        chk("rs0_valid", {63'd0, bus.rs0_valid}, {63'd0, ev[0]});
        chk("rs0_rdata", bus.rs0_rdata, ev[0] ? erd : 64'd0);
        chk("rs0_err", {63'd0, bus.rs0_err}, {63'd0, ev[0] && eer});
        chk("rs1_valid", {63'd0, bus.rs1_valid}, {63'd0, ev[1]});
        chk("rs1_rdata", bus.rs1_rdata, ev[1] ? erd : 64'd0);
        chk("rs1_err", {63'd0, bus.rs1_err}, {63'd0, ev[1] && eer});
        v = {bus.rq1_valid, bus.rq0_valid};
        eg = 2'b00;
        if (reset && cyc >= free_cyc && v != 2'b00)
            eg = (v == 2'b11) ? ((last == 0) ? 2'b10 : 2'b01) : v;
        chk("ready", {62'd0, bus.rq1_ready, bus.rq0_ready}, {62'd0, eg});
        if (eg != 2'b00) begin
            s.port = eg[1] ? 1 : 0;
            r = eg[1] ? q1.pop_front() : q0.pop_front();
            ok = in_range(r.addr);
            s.due = cyc + 2;
            s.err = !ok;
            s.rdata = (ok && !r.wr) ? gold[r.addr[12:3]] : 64'd0;
            pend.push_back(s);
            strb_cyc = cyc + 1;
            exp_rd = ok && !r.wr;
            exp_wr = ok && r.wr;
            wr_idx = int'(r.addr[12:3]);
            wr_dat = r.wdata;
            free_cyc = cyc + 3;
            last = s.port;
            if (eg[1]) gap1 = gaps_on ? $urandom_range(0, 2) : 0;
            else gap0 = gaps_on ? $urandom_range(0, 2) : 0;
        end
        if (!reset) begin
            pend.delete();
            last = 1;
            strb_cyc = -1;
            free_cyc = 0;
        end
        rst_prev_low = !reset;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && pend.size() == 0)
                break;
            step();
        end
        chk("drain_timeout", {63'd0, i >= budget}, 64'd0);
        step();
    endtask

    task automatic push(input int p, input logic wr,
                        input logic [63:0] a, input logic [63:0] d);
        req_t r;
        r.wr = wr;
        r.addr = a;
        r.wdata = d;
        if (p == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    function automatic logic [63:0] rnd_addr();
        logic [63:0] a;
        logic [63:0] edges [3];
        edges[0] = 64'h1FF8;
        edges[1] = 64'h2000;
        edges[2] = 64'hFFFF_FFFF_FFFF_FFF8;
        case ($urandom_range(0, 7))
            5: a = 64'($urandom_range(0, 31)) * 8 + 64'($urandom_range(1, 7));
            6: a = 64'h2000 + 64'($urandom_range(0, 511)) * 8;
            7: a = edges[$urandom_range(0, 2)];
            default: a = 64'($urandom_range(0, 31)) * 8;
        endcase
        return a;
    endfunction

    initial begin
        int i;
        for (int k = 0; k < 1024; k++) begin
            ram[k] = 64'd0;
            gold[k] = 64'd0;
        end
        bus.rq0_valid = 0;
        bus.rq0_write = 0;
        bus.rq0_addr = 0;
        bus.rq0_wdata = 0;
        bus.rq1_valid = 0;
        bus.rq1_write = 0;
        bus.rq1_addr = 0;
        bus.rq1_wdata = 0;
        step();
        step();

        push(0, 1, 64'h10, 64'hDEADBEEF_00C0FFEE);
        push(0, 0, 64'h10, 64'd0);
        reset = 1'b1;
        drain(50);

        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(0, 0, 64'(k * 8), 64'd0);
            push(1, 0, 64'(k * 8 + 64), 64'd0);
        end
        drive();
        drain(60);

        push(1, 0, 64'h13, 64'd0);
        push(0, 1, 64'h2000, 64'h1234);
        push(0, 0, 64'h1FF8, 64'd0);
        push(0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0);
        drive();
        drain(60);

        push(0, 1, 64'h40, 64'hCAFE_F00D_1234_5678);
        drive();
        for (i = 0; i < 20; i++) begin
            step();
            if (strb_cyc == cyc + 1) break;
        end
        chk("hs_timeout", {63'd0, i >= 20}, 64'd0);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        push(0, 0, 64'h40, 64'd0);
        push(1, 0, 64'h48, 64'd0);
        drive();
        drain(50);

        for (int k = 0; k < 5; k++) push(1, 0, 64'(k * 8), 64'd0);
        drive();
        drain(60);

        gaps_on = 1;
        for (int k = 0; k < 80; k++)
            push($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                 rnd_addr(), {$urandom, $urandom});
        drive();
        drain(2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
